// File: rtl/sipo_deser.sv
// sipo_deser: serial-in / parallel-out deserializer.
// Collects N words of WIDTH bits into one frame. The frame is presented on
// dout through a one-entry output buffer with a valid/ready handshake. A frame
// that completes while the buffer is still held is dropped, and the sticky ovf
// flag records the loss.
module sipo_deser #(
  parameter int N     = 4,
  parameter int WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 clr,
  input  logic                 en,
  input  logic [WIDTH-1:0]     si,
  output logic [N*WIDTH-1:0]   dout,
  output logic                 dvalid,
  input  logic                 dready,
  output logic                 ovf
);

  localparam int FW = N * WIDTH;
  localparam int CW = (N > 2) ? $clog2(N) : 1;

  // A frame needs at least two words. Below that, the shift path degenerates.
  if (N < 2) begin : g_bad_n
    $error("sipo_deser: N must be at least 2");
  end

  logic [FW-1:0] sh_q,     sh_d;
  logic [CW-1:0] cnt_q,    cnt_d;
  logic [FW-1:0] dout_q,   dout_d;
  logic          dvalid_q, dvalid_d;
  logic          ovf_q,    ovf_d;

  logic          last_word;
  logic          complete;
  logic          handshake;
  logic [FW-1:0] frame;

  // Decode the events for this cycle: word acceptance, frame completion, and consumer take.
  always_comb begin
    last_word = (cnt_q == CW'(N - 1));
    complete  = en && last_word;
    handshake = dvalid_q && dready;
    // New words enter at the top, so the first word of a frame ends up in the LSBs.
    frame     = {si, sh_q[FW-1:WIDTH]};
  end

  // Next-state logic for the shifter, word counter, output buffer and overflow flag.
  always_comb begin
    // NOTE: every variable gets its hold value first, so no path can leave one
    // unassigned and infer a latch.
    sh_d     = sh_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;
    dvalid_d = dvalid_q;
    ovf_d    = ovf_q;

    if (clr) begin
      // Flush the partial frame, the buffered frame and the flag. dout keeps its last value.
      sh_d     = '0;
      cnt_d    = '0;
      dvalid_d = 1'b0;
      ovf_d    = 1'b0;
    end else begin
      if (handshake) begin
        dvalid_d = 1'b0;
      end
      if (en) begin
        sh_d  = frame;
        cnt_d = last_word ? '0 : cnt_q + CW'(1);
        if (complete) begin
          if (!dvalid_q || dready) begin
            // The buffer is free, or it drains on this same edge, so the new frame takes the slot.
            dout_d   = frame;
            dvalid_d = 1'b1;
          end else begin
            // The buffer is still held, so the new frame is lost.
            ovf_d = 1'b1;
          end
        end
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: sequential state uses non-blocking assignments. Every register then
    // samples its pre-edge inputs, whatever order the blocks are evaluated in.
    if (!rstn) begin
      sh_q     <= '0;
      cnt_q    <= '0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      sh_q     <= sh_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      ovf_q    <= ovf_d;
    end
  end

  assign dout   = dout_q;
  assign dvalid = dvalid_q;
  assign ovf    = ovf_q;

endmodule
